// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Holds the FSM encoding and the bit-counter sizing helper.
package serial_add_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold 0..WIDTH-1 without wrapping; sized for 0..WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_add_seq_if.sv
// Operand/result handshake bundle for serial_add_seq.
// master = operand producer and result consumer; slave = the adder.
interface serial_add_seq_if #(
    parameter int WIDTH = 8
);
    logic             START_VALID;
    logic             START_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             ABORT;
    logic             SUM_VALID;
    logic             SUM_READY;
    logic [WIDTH-1:0] SUM;
    logic             COUT;
    logic             BUSY;

    modport master (
        output START_VALID, A, B, CIN, ABORT, SUM_READY,
        input  START_READY, SUM_VALID, SUM, COUT, BUSY
    );

    modport slave (
        input  START_VALID, A, B, CIN, ABORT, SUM_READY,
        output START_READY, SUM_VALID, SUM, COUT, BUSY
    );
endinterface

// File: rtl/serial_add_seq_fa.sv
// One-bit full-adder cell; the only arithmetic element of the serial adder.
module serial_add_seq_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first through one
// full-adder cell over WIDTH cycles, with valid/ready on both sides.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic              CLK,
    input logic              RESETN,
    serial_add_seq_if.slave  bus
);
    localparam int              CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_q;
    logic             carry_q, cout_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fa_s, fa_co;
    logic [WIDTH:0]   sum_shift;
    logic             accept, run_step, last_bit;
    logic             start_ready, sum_valid, busy;

    serial_add_seq_fa u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special case.
    assign sum_shift = {fa_s, sum_sr};
    assign last_bit  = (cnt_q == LAST);
    assign run_step  = (state_q == RUN) && !bus.ABORT;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        sum_valid   = 1'b0;
        busy        = 1'b0;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (bus.START_VALID) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (bus.ABORT)     state_d = IDLE;
                else if (last_bit) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                sum_valid = 1'b1;
                if (bus.ABORT || bus.SUM_READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: datapath registers are reset too, so a partial result can never leak out after reset.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_sr    <= bus.A;
            b_sr    <= bus.B;
            carry_q <= bus.CIN;
            cnt_q   <= '0;
        end else if (run_step) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            sum_sr  <= sum_shift[WIDTH:1];
            carry_q <= fa_co;
            // Result is published only on the final bit, so SUM/COUT stay put
            // through RUN and after the result has been consumed.
            if (last_bit) begin
                sum_q  <= sum_shift[WIDTH:1];
                cout_q <= fa_co;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.START_READY = start_ready;
    assign bus.SUM_VALID   = sum_valid;
    assign bus.BUSY        = busy;
    assign bus.SUM         = sum_q;
    assign bus.COUT        = cout_q;

endmodule
